// File: rtl/sensor_frame_uart_tx_if.sv
// Bundles the payload handshake and UART-side status signals of
// sensor_frame_uart_tx so the producer and the transmitter connect through
// one port.
interface sensor_frame_uart_tx_if;
  logic [101:0] sensor_iterations;
  logic         data_avl;
  logic         tx;
  logic         busy;
  logic [7:0]   frames_dropped;

  // Producer side: drives the payload strobe and observes line status.
  modport master (
    output sensor_iterations,
    output data_avl,
    input  tx,
    input  busy,
    input  frames_dropped
  );

  // Transmitter side.
  modport slave (
    input  sensor_iterations,
    input  data_avl,
    output tx,
    output busy,
    output frames_dropped
  );
endinterface

// File: rtl/sensor_frame_uart_tx.sv
// sensor_frame_uart_tx: serialises a 102-bit sensor word into a 15-byte
// 8N1 UART frame (SYNC, P0..P12, XOR checksum). One pending frame can wait
// behind the frame on the line; overwriting it bumps a saturating counter.
module sensor_frame_uart_tx #(
  parameter int          CLKS_PER_BIT = 625,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic                 clk_72MHz,
  input  logic                 reset,
  sensor_frame_uart_tx_if.slave sif
);

  localparam int             TW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0]  TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]     LAST_BYTE  = 4'd14;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state_reg, state_next;
  logic [TW-1:0]  timer_reg, timer_next;
  logic [2:0]     bit_idx_reg, bit_idx_next;
  logic [3:0]     byte_idx_reg, byte_idx_next;
  logic [7:0]     shift_reg, shift_next;
  logic [103:0]   active_reg, active_next;
  logic [7:0]     chk_reg, chk_next;
  logic [103:0]   pend_reg, pend_next;
  logic           pend_valid_reg, pend_valid_next;
  logic [7:0]     dropped_reg, dropped_next;
  logic           tx_reg, tx_next;

  logic           bit_end;
  logic           start_frame;
  logic           promote;
  logic           direct_start;
  logic           drop_inc;
  logic [103:0]   start_payload;
  logic [103:0]   in_payload;

  assign in_payload = {2'b00, sif.sensor_iterations};

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk_72MHz or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      bit_idx_reg    <= '0;
      byte_idx_reg   <= '0;
      shift_reg      <= '0;
      active_reg     <= '0;
      chk_reg        <= '0;
      pend_reg       <= '0;
      pend_valid_reg <= 1'b0;
      dropped_reg    <= '0;
      tx_reg         <= 1'b1;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      bit_idx_reg    <= bit_idx_next;
      byte_idx_reg   <= byte_idx_next;
      shift_reg      <= shift_next;
      active_reg     <= active_next;
      chk_reg        <= chk_next;
      pend_reg       <= pend_next;
      pend_valid_reg <= pend_valid_next;
      dropped_reg    <= dropped_next;
      tx_reg         <= tx_next;
    end
  end

  // Next-state logic: bit timing, byte sequencing, pending slot and line level.
  always_comb begin
    state_next      = state_reg;
    timer_next      = timer_reg;
    bit_idx_next    = bit_idx_reg;
    byte_idx_next   = byte_idx_reg;
    shift_next      = shift_reg;
    active_next     = active_reg;
    chk_next        = chk_reg;
    pend_next       = pend_reg;
    pend_valid_next = pend_valid_reg;
    dropped_next    = dropped_reg;
    tx_next         = 1'b1;
    start_frame     = 1'b0;
    promote         = 1'b0;
    drop_inc        = 1'b0;
    start_payload   = in_payload;
    bit_end         = (timer_reg == TIMER_LAST);

    case (state_reg)
      IDLE: begin
        if (sif.data_avl) start_frame = 1'b1;
      end
      START: begin
        if (bit_end) begin
          timer_next   = '0;
          bit_idx_next = '0;
          state_next   = DATA;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_next = '0;
          shift_next = shift_reg >> 1;
          if (bit_idx_reg == 3'd7) state_next = STOP;
          else                     bit_idx_next = bit_idx_reg + 3'd1;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          timer_next = '0;
          if (byte_idx_reg != LAST_BYTE) begin
            byte_idx_next = byte_idx_reg + 4'd1;
            state_next    = START;
            if (byte_idx_reg == LAST_BYTE - 4'd1) begin
              shift_next = chk_reg;
            end else begin
              // Payload bytes leave MSB-first, so peel the top byte off.
              shift_next  = active_reg[103:96];
              active_next = active_reg << 8;
              chk_next    = chk_reg ^ active_reg[103:96];
            end
          end else if (pend_valid_reg) begin
            promote       = 1'b1;
            start_frame   = 1'b1;
            start_payload = pend_reg;
          end else if (sif.data_avl) begin
            // A strobe in the very last cycle goes straight out with no gap.
            start_frame = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    if (start_frame) begin
      state_next    = START;
      active_next   = start_payload;
      chk_next      = '0;
      byte_idx_next = '0;
      bit_idx_next  = '0;
      timer_next    = '0;
      shift_next    = SYNC_BYTE;
    end

    // Pending slot: a promotion frees it in the same cycle a new strobe may fill it.
    direct_start = start_frame && !promote;
    if (promote) pend_valid_next = 1'b0;
    if (sif.data_avl && !direct_start) begin
      pend_next = in_payload;
      if (pend_valid_reg && !promote) drop_inc = 1'b1;
      else                            pend_valid_next = 1'b1;
    end
    if (drop_inc && dropped_reg != 8'hFF) dropped_next = dropped_reg + 8'd1;

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  assign sif.tx             = tx_reg;
  assign sif.busy           = (state_reg != IDLE) | pend_valid_reg;
  assign sif.frames_dropped = dropped_reg;

endmodule
